// File: rtl/mem_arb_pkg.sv
// Shared types for the program-memory port arbiter: load sizes, FSM states
// and the round-robin grant owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_align.sv
// Combinational load aligner: range/alignment checking plus byte/half/word
// extraction with sign or zero extension. Shared by fetch and data ports.
module load_align
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned DATA_W    = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [31:0]       addr,
  input  size_e             size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic u);
    logic signed [7:0] s;
    s = signed'(b);
    return u ? DATA_W'(b) : DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic u);
    logic signed [15:0] s;
    s = signed'(h);
    return u ? DATA_W'(h) : DATA_W'(s);
  endfunction

  logic [2:0]  nbytes;
  logic        misaligned;
  logic        reserved;
  logic [32:0] end_addr;
  logic [DATA_W-1:0] raw;

  always_comb begin
    nbytes     = 3'd4;
    misaligned = 1'b0;
    reserved   = 1'b0;
    raw        = rdata;
    case (size)
      SZ_B: begin
        nbytes = 3'd1;
        raw    = ext_byte(rdata[7:0], is_unsigned);
      end
      SZ_H: begin
        nbytes     = 3'd2;
        misaligned = addr[0];
        raw        = ext_half(rdata[15:0], is_unsigned);
      end
      SZ_W: begin
        nbytes     = 3'd4;
        misaligned = (addr[1:0] != 2'b00);
      end
      SZ_RSV: begin
        reserved = 1'b1;
      end
    endcase
    // 33-bit sum so addresses just below 2^32 cannot wrap into range
    end_addr = {1'b0, addr} + 33'(nbytes);
    err      = reserved | misaligned | (end_addr > 33'(MEM_BYTES));
    data     = err ? '0 : raw;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read program memory between
// the fetch port and the load port; one registered response outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [31:0]       i_req_addr,
  output logic              i_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_req_addr,
  input  logic [1:0]        d_req_size,
  input  logic              d_req_unsigned,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  grant_e            last_grant;
  logic              idle;
  logic              gnt_i;
  logic              gnt_d;
  size_e             al_size;
  logic              al_uns;
  logic [DATA_W-1:0] al_data;
  logic              al_err;
  logic [DATA_W-1:0] data_p1;
  logic              err_p1;

  // Accept stage: ready depends only on the other port's valid
  assign idle        = (state == IDLE) && !rst;
  assign i_req_ready = idle && (!d_req_valid || last_grant == GNT_D);
  assign d_req_ready = idle && (!i_req_valid || last_grant == GNT_I);
  assign gnt_i       = i_req_valid && i_req_ready;
  assign gnt_d       = d_req_valid && d_req_ready;

  assign mem_addr = gnt_i ? i_req_addr : (gnt_d ? d_req_addr : 32'd0);
  assign al_size  = gnt_i ? SZ_W : size_e'(d_req_size);
  assign al_uns   = gnt_i | d_req_unsigned;

  load_align #(
    .MEM_BYTES(MEM_BYTES),
    .DATA_W   (DATA_W)
  ) u_align (
    .rdata      (mem_rdata),
    .addr       (mem_addr),
    .size       (al_size),
    .is_unsigned(al_uns),
    .data       (al_data),
    .err        (al_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      data_p1    <= '0;
      err_p1     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_i || gnt_d) begin
            state      <= gnt_i ? RESP_I : RESP_D;
            last_grant <= gnt_i ? GNT_I : GNT_D;
            data_p1    <= al_data;
            err_p1     <= al_err;
          end
        end
        RESP_I:  if (i_resp_ready) state <= IDLE;
        RESP_D:  if (d_resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response stage: outputs of the idle port are held at zero
  assign i_resp_valid = (state == RESP_I);
  assign d_resp_valid = (state == RESP_D);
  assign i_resp_data  = i_resp_valid ? data_p1 : '0;
  assign i_resp_err   = i_resp_valid & err_p1;
  assign d_resp_data  = d_resp_valid ? data_p1 : '0;
  assign d_resp_err   = d_resp_valid & err_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-array memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
  logic [31:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_req_unsigned, d_resp_valid, d_resp_ready, d_resp_err;
  logic [31:0] d_req_addr, d_resp_data;
  logic [1:0]  d_req_size;
  logic [31:0] mem_addr, mem_rdata;

  logic [7:0]  mem [256];
  logic [7:0]  a0, a1, a2, a3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  mem_port_arbiter #(.MEM_BYTES(256), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one load and returns what the response cycle showed.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         output logic v, output logic [31:0] dat, output logic e);
    d_req_addr = a; d_req_size = sz; d_req_unsigned = u; d_req_valid = 1'b1;
    #1;
    for (int n = 0; n < 8 && d_req_ready !== 1'b1; n++) step();
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_timeout addr=%h got ready=%b want 1", a, d_req_ready);
    end
    step();
    d_req_valid = 1'b0;
    v = d_resp_valid; dat = d_resp_data; e = d_resp_err;
    d_resp_ready = 1'b1;
    step();
    d_resp_ready = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a,
                          output logic v, output logic [31:0] dat, output logic e);
    i_req_addr = a; i_req_valid = 1'b1;
    #1;
    for (int n = 0; n < 8 && i_req_ready !== 1'b1; n++) step();
    checks++;
    if (i_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ready_timeout addr=%h got ready=%b want 1", a, i_req_ready);
    end
    step();
    i_req_valid = 1'b0;
    v = i_resp_valid; dat = i_resp_data; e = i_resp_err;
    i_resp_ready = 1'b1;
    step();
    i_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    i_req_addr = 32'h4; d_req_addr = 32'h10; d_req_size = 2'b10; d_req_unsigned = 1'b0;
    i_resp_ready = 1'b0; d_resp_ready = 1'b0;
    step(); step();
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %b want 0", i_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %b want 0", d_req_ready); end
    checks++; if (i_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_i_resp_valid got %b want 0", i_resp_valid); end
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_d_resp_valid got %b want 0", d_resp_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    checks++; if (i_resp_data !== 32'h0 || d_resp_data !== 32'h0) begin
      errors++; $display("FAIL rst_resp_data got i=%h d=%h want 0", i_resp_data, d_resp_data);
    end
    rst = 1'b0;
    #1;
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL rel_i_ready got %b want 1", i_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL rel_d_ready got %b want 0", d_req_ready); end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    #1;
  endtask

  task automatic test_contention();
    logic        exp_i;
    logic [31:0] got;
    i_req_addr = 32'h4; d_req_addr = 32'h10; d_req_size = 2'b10; d_req_unsigned = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      checks++; if (i_req_ready !== exp_i) begin errors++; $display("FAIL cont_i_ready[%0d] got %b want %b", k, i_req_ready, exp_i); end
      checks++; if (d_req_ready !== !exp_i) begin errors++; $display("FAIL cont_d_ready[%0d] got %b want %b", k, d_req_ready, !exp_i); end
      checks++; if (mem_addr !== (exp_i ? 32'h4 : 32'h10)) begin errors++; $display("FAIL cont_mem_addr[%0d] got %h", k, mem_addr); end
      step();
      checks++; if (i_resp_valid !== exp_i) begin errors++; $display("FAIL cont_i_resp_valid[%0d] got %b want %b", k, i_resp_valid, exp_i); end
      checks++; if (d_resp_valid !== !exp_i) begin errors++; $display("FAIL cont_d_resp_valid[%0d] got %b want %b", k, d_resp_valid, !exp_i); end
      checks++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
        errors++; $display("FAIL cont_busy_ready[%0d] got i=%b d=%b want 0", k, i_req_ready, d_req_ready);
      end
      got = exp_i ? i_resp_data : d_resp_data;
      checks++; if (got !== (exp_i ? 32'h00100093 : 32'h1234F080)) begin
        errors++; $display("FAIL cont_data[%0d] got %h", k, got);
      end
      step();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_resp_ready = 1'b0; d_resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_fetch();
    logic v, e;
    logic [31:0] dat;
    i_req_addr = 32'h4; i_req_valid = 1'b1;
    #1;
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got %b want 1", i_req_ready); end
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL fetch_mem_addr got %h want 4", mem_addr); end
    step();
    i_req_valid = 1'b0;
    checks++; if (i_resp_valid !== 1'b1) begin errors++; $display("FAIL fetch_resp_valid got %b want 1", i_resp_valid); end
    checks++; if (i_resp_data !== 32'h00100093) begin errors++; $display("FAIL fetch_data got %h want 00100093", i_resp_data); end
    checks++; if (i_resp_err !== 1'b0) begin errors++; $display("FAIL fetch_err got %b want 0", i_resp_err); end
    i_resp_ready = 1'b1;
    step();
    i_resp_ready = 1'b0;
    checks++; if (i_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_taken got %b want 0", i_resp_valid); end
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL fetch_back_idle got %b want 1", d_req_ready); end
    do_fetch(32'hFFFFFFFC, v, dat, e);
    checks++; if ({v, e, dat} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL fetch_wrap got v=%b e=%b d=%h want v=1 e=1 d=0", v, e, dat);
    end
    do_fetch(32'h6, v, dat, e);
    checks++; if ({v, e, dat} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL fetch_misalign got v=%b e=%b d=%h want v=1 e=1 d=0", v, e, dat);
    end
  endtask

  task automatic test_loads();
    logic [31:0] t_addr [13] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h12, 32'hFC,
                                 32'hFF, 32'hFE, 32'h02, 32'h11, 32'hFD, 32'hFFFFFFFF};
    logic [1:0]  t_size [13] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10,
                                 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic        t_uns  [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_data [13] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080, 32'h0000F080,
                                 32'h1234F080, 32'h00000034, 32'hCAFEF00D, 32'hFFFFFFCA,
                                 32'h0000CAFE, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        t_err  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic v, e;
    logic [31:0] dat;
    for (int k = 0; k < 13; k++) begin
      do_load(t_addr[k], t_size[k], t_uns[k], v, dat, e);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL load_valid[%0d] got %b want 1", k, v); end
      checks++; if (dat !== t_data[k]) begin errors++; $display("FAIL load_data[%0d] got %h want %h", k, dat, t_data[k]); end
      checks++; if (e !== t_err[k]) begin errors++; $display("FAIL load_err[%0d] got %b want %b", k, e, t_err[k]); end
    end
    do_load(32'h10, 2'b11, 1'b0, v, dat, e);
    checks++; if ({v, e, dat} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL load_rsv got v=%b e=%b d=%h want v=1 e=1 d=0", v, e, dat);
    end
  endtask

  task automatic test_backpressure_reset();
    d_req_addr = 32'h10; d_req_size = 2'b10; d_req_unsigned = 1'b0; d_req_valid = 1'b1;
    #1;
    step();
    d_req_valid = 1'b0;
    i_req_addr = 32'h4; i_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (d_resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, d_resp_valid); end
      checks++; if (d_resp_data !== 32'h1234F080 || d_resp_err !== 1'b0) begin
        errors++; $display("FAIL bp_data[%0d] got %h err %b want 1234f080 err 0", k, d_resp_data, d_resp_err);
      end
      checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL bp_i_stall[%0d] got %b want 0", k, i_req_ready); end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL rstd_valid got %b want 0", d_resp_valid); end
    checks++; if (d_resp_data !== 32'h0 || d_resp_err !== 1'b0) begin
      errors++; $display("FAIL rstd_data got %h err %b want 0", d_resp_data, d_resp_err);
    end
    checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL rstd_idle got %b want 1", i_req_ready); end
    i_req_valid = 1'b0;
    d_resp_ready = 1'b1;
    step();
    d_resp_ready = 1'b0;
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL rstd_lost got %b want 0", d_resp_valid); end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    {mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]} = 32'h00100093;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h1234F080;
    {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'hCAFEF00D;
    test_reset();
    test_contention();
    test_fetch();
    test_loads();
    test_backpressure_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single combinational-read program memory (256-byte, little-endian, 32-bit window at any byte address) between the instruction-fetch port and the data-load port of the core. Arbitrates with round-robin priority, drives the memory address, and registers one response at a time. On the data port it extracts and sign- or zero-extends byte, half and word loads. It flags misaligned, reserved-size and out-of-range accesses instead of reading memory for them.

## Interface
- MEM_BYTES, 256: memory size in bytes; legal accesses satisfy addr + nbytes <= MEM_BYTES
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle when valid&&ready
- i_req_addr  in  32  fetch byte address
- i_resp_valid  out  1  fetch response held until taken
- i_resp_ready  in  1  fetch consumer takes response
- i_resp_data  out  32  instruction word
- i_resp_err  out  1  misaligned or out-of-range
- d_req_valid  in  1  load request
- d_req_ready  out  1  load request accepted
- d_req_addr  in  32  load byte address
- d_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- d_req_unsigned  in  1  zero-extend when 1, sign-extend when 0
- d_resp_valid / d_resp_ready / d_resp_data(32) / d_resp_err: same semantics as the fetch port
- mem_addr  out  32  address to memory; memory returns bytes addr..addr+3 combinationally
- mem_rdata  in  32  memory read data; byte at addr is in [7:0]

## Operation
- States: IDLE, RESP_I, RESP_D. Only one request is outstanding in total.
- IDLE arbitration:
  - One port valid: grant that port.
  - Both valid: grant the port not granted last. last_grant resets to D, so I wins the first tie.
  - Ready outputs:
    - i_req_ready = IDLE && (!d_req_valid || last_grant==D)
    - d_req_ready = IDLE && (!i_req_valid || last_grant==I)
  - Ready may depend on the other port's valid, never on its own valid.
- Accept cycle:
  - mem_addr = granted address (0 when nothing is granted).
  - Response register captures the result; last_grant is updated.
  - State moves to RESP_x.
- RESP_x:
  - x_resp_valid = 1; data and err are stable.
  - On x_resp_valid && x_resp_ready the state goes to IDLE.
  - No new request is accepted in that same cycle.
- Fetch: nbytes = 4. err if addr[1:0]!=0 or addr+4 > MEM_BYTES.
- Load:
  - nbytes is 1, 2 or 4.
  - err if size==11, half with addr[0]==1, word with addr[1:0]!=0, or addr+nbytes > MEM_BYTES. Compute the range check in 33 bits; addresses near 2^32 must not wrap.
  - byte: rdata[7:0] extended from bit 7. half: rdata[15:0] extended from bit 15. word: rdata unchanged.
- Whenever err=1, data=0.

## Timing
- Reset values:
  - state=IDLE, last_grant=D.
  - All resp_valid, resp_data and resp_err outputs are 0.
  - mem_addr = 0 when no request is valid.
- Latency: request accepted in cycle N gives resp_valid in cycle N+1.
- Throughput: at most one transaction per 2 cycles (accept, then respond-and-take).
- A response whose resp_ready stays low is held indefinitely, and the other port stalls for that time (ready=0).
- Reset asserted in any state drops the pending response: the next cycle is IDLE with all outputs at their reset values.
- Requests with valid=1 and ready=0 must keep address, size and unsigned stable. The block does not latch them.

## Structure
- Package mem_arb_pkg:
  - size enum: SZ_B, SZ_H, SZ_W, SZ_RSV
  - state enum: IDLE, RESP_I, RESP_D
  - grant enum: GNT_I, GNT_D
- Sub-module load_align: combinational. Inputs rdata, addr, size, unsigned and MEM_BYTES; outputs data and err. Used for both ports; fetch is a word with unsigned=1.

## Test plan
- Reset: hold rst 2 cycles with both requests valid -> no ready, resp_valid=0, mem_addr=0. Release -> i_req_ready=1 and d_req_ready=0 on the first cycle.
- Fetch: i_req addr 0x04, mem_rdata 0x00100093 -> i_resp_valid next cycle, data 0x00100093, err 0. With resp_ready=1 -> IDLE the next cycle.
- Contention: both valid continuously, resp_ready=1 -> grants I, D, I, D, each 2 cycles apart; d_req_ready never 1 while in RESP_I.
- Load extension, mem_rdata 0x1234F080 at 0x10:
  - lb -> 0xFFFFFF80; lbu -> 0x00000080
  - lh -> 0xFFFFF080; lhu -> 0x0000F080
  - lw -> 0x1234F080
- Errors, all with data 0 and err 1: lw at 0x02; lh at 0x11; size 11 at 0x10; lw at 0xFD (MEM_BYTES=256); fetch at 0xFFFFFFFC.
- Backpressure and reset: d_resp_ready low for 5 cycles -> response is stable and i_req_ready stays 0. Assert rst in RESP_D -> next cycle IDLE, d_resp_valid=0, and the pending response is lost.
